// File: rtl/vfmul_sequencer.sv
// Element sequencer for a vector FP32 multiply: walks a vector of operand
// pairs out of the register file, feeds them through an external
// combinational multiplier, and writes the products back in element order.
module vfmul_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_vl,
    input  logic [4:0]  cmd_vs1,
    input  logic [4:0]  cmd_vs2,
    input  logic [4:0]  cmd_vd,
    output logic        rd_en,
    output logic [4:0]  rd_vreg_a,
    output logic [4:0]  rd_vreg_b,
    output logic [4:0]  rd_idx,
    input  logic [31:0] rd_data_a,
    input  logic [31:0] rd_data_b,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_y,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [4:0]  wr_vreg,
    output logic [4:0]  wr_idx,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        nan_seen
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  vs1_q, vs2_q, vd_q;
    logic [5:0]  vl_q;
    logic [5:0]  issue_idx_q;
    logic        inflight_q;
    logic [4:0]  inflight_idx_q;
    logic [31:0] fifo_a_q   [0:1];
    logic [31:0] fifo_b_q   [0:1];
    logic [4:0]  fifo_idx_q [0:1];
    logic        fifo_wr_ptr_q, fifo_rd_ptr_q;
    logic [1:0]  fifo_cnt_q;
    logic        res_valid_q;
    logic [31:0] res_data_q;
    logic [4:0]  res_idx_q, res_vreg_q;
    logic        done_q, nan_q;

    logic        accept, fifo_empty, wr_fire, pop, push, issue_ok;
    logic        last_issue, last_write, nan_wr;
    logic [5:0]  vl_eff;
    logic [2:0]  occupancy;

    // Handshake, FIFO and throttle decode shared by the FSM and datapath
    always_comb begin
        accept     = cmd_valid && cmd_ready;
        vl_eff     = (cmd_vl > 6'd32) ? 6'd32 : cmd_vl;
        fifo_empty = (fifo_cnt_q == 2'd0);
        wr_fire    = res_valid_q && wr_ready;
        pop        = !fifo_empty && (!res_valid_q || wr_fire);
        push       = inflight_q;
        // Slots the FIFO will need once this cycle's pop and the in-flight read settle
        occupancy  = {1'b0, fifo_cnt_q} - {2'b00, pop} + {2'b00, inflight_q};
        issue_ok   = (occupancy < 3'd2);
        last_issue = rd_en && (issue_idx_q == vl_q - 6'd1);
        last_write = wr_fire && (state_q == DRAIN) && ({1'b0, res_idx_q} == vl_q - 6'd1);
        nan_wr     = wr_fire && (res_data_q[30:23] == 8'hFF) && (res_data_q[22:0] != 23'd0);
    end

    // Next-state and handshake outputs of the sequencing FSM
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        rd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (vl_eff != 6'd0)) state_d = ISSUE;
            end
            ISSUE: begin
                busy  = 1'b1;
                rd_en = issue_ok;
                if (last_issue) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_write) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Command latch, read index counter and in-flight read tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            vs1_q          <= 5'd0;
            vs2_q          <= 5'd0;
            vd_q           <= 5'd0;
            vl_q           <= 6'd0;
            issue_idx_q    <= 6'd0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= 5'd0;
        end else begin
            if (accept) begin
                vs1_q       <= cmd_vs1;
                vs2_q       <= cmd_vs2;
                vd_q        <= cmd_vd;
                vl_q        <= vl_eff;
                issue_idx_q <= 6'd0;
            end else if (rd_en) begin
                issue_idx_q <= issue_idx_q + 6'd1;
            end
            inflight_q     <= rd_en;
            inflight_idx_q <= issue_idx_q[4:0];
        end
    end

    // Operand FIFO storage: returning read data lands in the write-pointer slot
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            always_ff @(posedge clk) begin
                if (reset) begin
                    fifo_a_q[gi]   <= 32'd0;
                    fifo_b_q[gi]   <= 32'd0;
                    fifo_idx_q[gi] <= 5'd0;
                end else if (push && (fifo_wr_ptr_q == 1'(gi))) begin
                    fifo_a_q[gi]   <= rd_data_a;
                    fifo_b_q[gi]   <= rd_data_b;
                    fifo_idx_q[gi] <= inflight_idx_q;
                end
            end
        end
    endgenerate

    // Operand FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_wr_ptr_q <= 1'b0;
            fifo_rd_ptr_q <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            if (push) fifo_wr_ptr_q <= ~fifo_wr_ptr_q;
            if (pop)  fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Result register: captures the product of the FIFO head, holds under backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            res_data_q  <= 32'd0;
            res_idx_q   <= 5'd0;
            res_vreg_q  <= 5'd0;
        end else if (pop) begin
            res_valid_q <= 1'b1;
            res_data_q  <= mul_y;
            res_idx_q   <= fifo_idx_q[fifo_rd_ptr_q];
            res_vreg_q  <= vd_q;
        end else if (wr_fire) begin
            res_valid_q <= 1'b0;
        end
    end

    // Completion pulse and sticky NaN flag
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
            nan_q  <= 1'b0;
        end else begin
            done_q <= (accept && (vl_eff == 6'd0)) || last_write;
            if (accept)      nan_q <= 1'b0;
            else if (nan_wr) nan_q <= 1'b1;
        end
    end

    assign rd_vreg_a = vs1_q;
    assign rd_vreg_b = vs2_q;
    assign rd_idx    = issue_idx_q[4:0];
    assign mul_a     = fifo_empty ? 32'd0 : fifo_a_q[fifo_rd_ptr_q];
    assign mul_b     = fifo_empty ? 32'd0 : fifo_b_q[fifo_rd_ptr_q];
    assign wr_valid  = res_valid_q;
    assign wr_vreg   = res_vreg_q;
    assign wr_idx    = res_idx_q;
    assign wr_data   = res_data_q;
    assign done      = done_q;
    assign nan_seen  = nan_q;

endmodule

// File: tb/tb_vfmul_sequencer.sv
// Directed-plus-random bench for vfmul_sequencer: a vector register file
// responder and FP32 multiplier model surround the DUT, and each command's
// reads, writes and done pulse are compared against the expected sequence.
module tb_vfmul_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [5:0]  cmd_vl;
    logic [4:0]  cmd_vs1, cmd_vs2, cmd_vd;
    logic        rd_en;
    logic [4:0]  rd_vreg_a, rd_vreg_b, rd_idx;
    logic [31:0] rd_data_a, rd_data_b;
    logic [31:0] mul_a, mul_b, mul_y;
    logic        wr_valid, wr_ready;
    logic [4:0]  wr_vreg, wr_idx;
    logic [31:0] wr_data;
    logic        busy, done, nan_seen;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] vrf [32][32];

    // Per-command observation record
    int          rq_idx[$], rq_cyc[$];
    int          wq_idx[$], wq_cyc[$], wq_vreg[$];
    logic [31:0] wq_data[$];
    int          done_n, done_cyc;

    vfmul_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vl(cmd_vl),
        .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd),
        .rd_en(rd_en), .rd_vreg_a(rd_vreg_a), .rd_vreg_b(rd_vreg_b), .rd_idx(rd_idx),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_vreg(wr_vreg),
        .wr_idx(wr_idx), .wr_data(wr_data),
        .busy(busy), .done(done), .nan_seen(nan_seen)
    );

    always #5 clk = ~clk;

    // FP32 multiply for normal operands (truncating), NaN propagates as qNaN
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] ma, mb, p;
        logic [22:0] m;
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
            return 32'h7FC00000;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        ma = {24'd0, 1'b1, a[22:0]};
        mb = {24'd0, 1'b1, b[22:0]};
        p  = ma * mb;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e = e + 1;
            m = p[46:24];
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        return {s, 8'(e), m};
    endfunction

    assign mul_y = fmul(mul_a, mul_b);

    // Register file responder: data valid the cycle after rd_en, junk otherwise
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= vrf[rd_vreg_a][rd_idx];
            rd_data_b <= vrf[rd_vreg_b][rd_idx];
        end else begin
            rd_data_a <= $urandom;
            rd_data_b <= $urandom;
        end
    end

    function automatic logic [31:0] rnd_f();
        return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one command and observe until done (+2 quiet cycles) or budget expiry
    task automatic run_op(input int vl, input logic [4:0] vs1, input logic [4:0] vs2,
                          input logic [4:0] vd, input int stall_at, input int stall_len,
                          output logic nan_first, output logic nan_end);
        int          eff, issued, written, out_now, max_out, post, addr_bad;
        logic        held_v;
        logic [31:0] held_d;
        logic [4:0]  held_i;
        bit          finished;
        eff = (vl > 32) ? 32 : vl;
        issued = 0; written = 0; max_out = 0; post = 0; addr_bad = 0;
        held_v = 1'b0; held_d = 32'd0; held_i = 5'd0; finished = 1'b0;
        nan_first = 1'b0;
        rq_idx.delete(); rq_cyc.delete();
        wq_idx.delete(); wq_cyc.delete(); wq_vreg.delete(); wq_data.delete();
        done_n = 0; done_cyc = -1;

        @(negedge clk);
        cmd_valid = 1'b1; cmd_vl = 6'(vl); cmd_vs1 = vs1; cmd_vs2 = vs2; cmd_vd = vd;
        wr_ready = 1'b1;
        #1;
        chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);

        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            // Junk command presented while busy must be ignored
            cmd_valid = (eff >= 4) && (cyc == 1 || cyc == 2);
            cmd_vl = 6'($urandom); cmd_vs1 = 5'($urandom);
            cmd_vs2 = 5'($urandom); cmd_vd = 5'($urandom);
            wr_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            if (cyc == 0) nan_first = nan_seen;
            out_now = issued - written - int'(wr_valid);
            if (out_now > max_out) max_out = out_now;
            if (held_v) begin
                chk("stall_hold_valid", 32'(wr_valid), 32'd1);
                chk("stall_hold_data", wr_data, held_d);
                chk("stall_hold_idx", 32'(wr_idx), 32'(held_i));
            end
            held_v = wr_valid && !wr_ready;
            held_d = wr_data;
            held_i = wr_idx;
            if (rd_en) begin
                rq_idx.push_back(int'(rd_idx));
                rq_cyc.push_back(cyc);
                issued++;
                if (rd_vreg_a != vs1 || rd_vreg_b != vs2) addr_bad++;
            end
            if (wr_valid && wr_ready) begin
                wq_idx.push_back(int'(wr_idx));
                wq_data.push_back(wr_data);
                wq_vreg.push_back(int'(wr_vreg));
                wq_cyc.push_back(cyc);
                written++;
                $display("[TB] write vreg=%0d idx=%0d data=%h cycle=%0d", wr_vreg, wr_idx, wr_data, cyc);
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
                chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
                chk("done_busy", 32'(busy), 32'd0);
            end
            if (done_n > 0) begin
                post++;
                if (post > 2) finished = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        nan_end = nan_seen;

        chk("done_count", 32'(done_n), 32'd1);
        chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
        chk("read_count", 32'(rq_idx.size()), 32'(eff));
        chk("write_count", 32'(wq_idx.size()), 32'(eff));
        chk("read_vreg", 32'(addr_bad), 32'd0);
        chk("max_outstanding_le2", 32'(max_out <= 2), 32'd1);
        for (int k = 0; k < eff && k < rq_idx.size(); k++)
            chk("read_idx", 32'(rq_idx[k]), 32'(k));
        for (int k = 0; k < eff && k < wq_idx.size(); k++) begin
            chk("write_idx", 32'(wq_idx[k]), 32'(k));
            chk("write_vreg", 32'(wq_vreg[k]), 32'(vd));
            chk("write_data", wq_data[k], fmul(vrf[vs1][k], vrf[vs2][k]));
        end
        if (stall_len == 0) begin
            chk("done_cycle", 32'(done_cyc), 32'(eff == 0 ? 0 : eff + 3));
            for (int k = 0; k < eff && k < rq_cyc.size(); k++)
                chk("read_cycle", 32'(rq_cyc[k]), 32'(k));
            for (int k = 0; k < eff && k < wq_cyc.size(); k++)
                chk("write_latency", 32'(wq_cyc[k]), 32'(k + 3));
        end
    endtask

    initial begin
        logic nf, ne;
        int   seen_wr, seen_done, seen_rd;
        for (int r = 0; r < 32; r++)
            for (int i = 0; i < 32; i++)
                vrf[r][i] = rnd_f();
        reset = 1'b1; cmd_valid = 1'b0; cmd_vl = 6'd0;
        cmd_vs1 = 5'd0; cmd_vs2 = 5'd0; cmd_vd = 5'd0; wr_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_nan_seen", 32'(nan_seen), 32'd0);
        chk("rst_rd_idx", 32'(rd_idx), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_mul_a", mul_a, 32'd0);

        // 2.0 * 3.0 over four elements
        for (int i = 0; i < 4; i++) begin
            vrf[1][i] = 32'h40000000;
            vrf[2][i] = 32'h40400000;
        end
        run_op(4, 5'd1, 5'd2, 5'd3, 0, 0, nf, ne);
        for (int k = 0; k < 4 && k < wq_data.size(); k++)
            chk("two_times_three", wq_data[k], 32'h40C00000);
        chk("basic_nan_clear", 32'(ne), 32'd0);

        // Zero length is a no-op with an immediate done
        run_op(0, 5'd4, 5'd5, 5'd6, 0, 0, nf, ne);

        // Length above 32 clamps to 32
        run_op(40, 5'd7, 5'd8, 5'd9, 0, 0, nf, ne);

        // Backpressure for 5 cycles mid-stream
        run_op(8, 5'd10, 5'd11, 5'd12, 5, 5, nf, ne);

        // NaN result sets the sticky flag; next accept clears it
        vrf[13][0] = 32'h7FC00000;
        vrf[14][0] = 32'h3F800000;
        run_op(1, 5'd13, 5'd14, 5'd15, 0, 0, nf, ne);
        chk("nan_set", 32'(ne), 32'd1);
        run_op(3, 5'd16, 5'd17, 5'd18, 0, 0, nf, ne);
        chk("nan_cleared_on_accept", 32'(nf), 32'd0);

        // Reset two edges after accepting vl=8 aborts the operation
        @(negedge clk);
        cmd_valid = 1'b1; cmd_vl = 6'd8; cmd_vs1 = 5'd19; cmd_vs2 = 5'd20; cmd_vd = 5'd21;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mul_a", mul_a, 32'd0);
        seen_wr = 0; seen_done = 0; seen_rd = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (wr_valid) seen_wr++;
            if (done) seen_done++;
            if (rd_en) seen_rd++;
            if (c == 0) chk("abort_late_data_dropped", mul_a, 32'd0);
        end
        chk("abort_no_wr_valid", 32'(seen_wr), 32'd0);
        chk("abort_no_done", 32'(seen_done), 32'd0);
        chk("abort_no_rd_en", 32'(seen_rd), 32'd0);

        // Randomized commands with random backpressure
        for (int r = 0; r < 4; r++) begin
            run_op($urandom_range(1, 63), 5'($urandom), 5'($urandom), 5'($urandom),
                   $urandom_range(0, 12), $urandom_range(0, 4), nf, ne);
            chk("rand_nan_clear", 32'(ne), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vfmul_sequencer.md
VFMUL_SEQUENCER -- requirements
Module: vfmul_sequencer

Interface
REQ-001 The block SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have ports `cmd_valid` (input, 1) and `cmd_ready` (output, 1): command handshake; a command is accepted on the cycle `cmd_valid` && `cmd_ready` are both high.
REQ-004 The block SHALL have port `cmd_vl`, input, 6 bits: vector length; 0 is a no-op; 33-63 are treated as 32.
REQ-005 The block SHALL have ports `cmd_vs1`, `cmd_vs2`, `cmd_vd`, each input, 5 bits: source A, source B and destination vector registers.
REQ-006 The block SHALL have port `rd_en`, output, 1 bit: element read request; `rd_data_a`/`rd_data_b` are valid exactly 1 cycle later.
REQ-007 The block SHALL have ports `rd_vreg_a`, `rd_vreg_b`, `rd_idx`, each output, 5 bits: read register addresses and element index.
REQ-008 The block SHALL have ports `rd_data_a`, `rd_data_b`, each input, 32 bits: FP32 element operands.
REQ-009 The block SHALL have ports `mul_a`, `mul_b`, each output, 32 bits: operands to the external combinational FP32 multiplier.
REQ-010 The block SHALL have port `mul_y`, input, 32 bits: the multiplier's combinational product.
REQ-011 The block SHALL have ports `wr_valid` (output, 1), `wr_ready` (input, 1), `wr_vreg` (output, 5), `wr_idx` (output, 5), `wr_data` (output, 32): result writeback handshake.
REQ-012 The block SHALL have ports `busy` (output, 1), `done` (output, 1, one-cycle pulse) and `nan_seen` (output, 1, sticky).

Function
REQ-013 The FSM SHALL have three states: IDLE, ISSUE and DRAIN; `cmd_ready` SHALL be 1 only in IDLE, and `busy` SHALL be 1 in ISSUE and DRAIN.
REQ-014 On command accept, the block SHALL latch vs1/vs2/vd and the effective vl, clear `nan_seen`, and go IDLE->ISSUE if vl>0, else stay in IDLE and pulse `done` on the next cycle.
REQ-015 In ISSUE, the block SHALL assert `rd_en` with `rd_idx` = 0,1,...,vl-1 in order; when the last index has been issued it SHALL go ISSUE->DRAIN.
REQ-016 The block SHALL push returning rd_data pairs into a 2-entry operand FIFO on the cycle after `rd_en`; `mul_a`/`mul_b` SHALL equal the FIFO head, or 0 when the FIFO is empty.
REQ-017 The block SHALL issue a read only if (FIFO count - pop this cycle + reads in flight) < 2, so the FIFO never overflows.
REQ-018 The result register SHALL load `mul_y`, the head index and vd, and pop the FIFO, when the FIFO is non-empty and (the result register is empty or `wr_valid` && `wr_ready`).
REQ-019 `wr_valid` SHALL be high while the result register is full; the result register SHALL hold its contents while `wr_ready` is low, and that stall SHALL propagate back through the FIFO to read issue.
REQ-020 Writes SHALL occur in element order, exactly once each, with `wr_vreg` = the latched vd.
REQ-021 With `wr_ready` held at 1, throughput SHALL be 1 element per cycle, with latency from `rd_en` to `wr_valid` of 3 cycles for the same element.
REQ-022 In DRAIN, the block SHALL pulse `done` for one cycle on the cycle after the final write handshake, and go DRAIN->IDLE in that same cycle.
REQ-023 `nan_seen` SHALL be set on any write handshake where `wr_data`[30:23]==8'hFF and `wr_data`[22:0]!=0, and SHALL hold until the next command accept.
REQ-024 The block SHALL ignore `cmd_valid` while busy; the command inputs need not be held stable after accept.

Reset
REQ-025 With `reset` high at a clock edge, the next state SHALL be IDLE, and `cmd_ready`=1, `busy`=0, `done`=0, `rd_en`=0, `wr_valid`=0, `nan_seen`=0.
REQ-026 On reset, the FIFO, in-flight tracking and result register SHALL be emptied, and all address/data outputs SHALL be 0.
REQ-027 A reset asserted mid-operation SHALL abort the operation: no further `rd_en` or `wr_valid`, no `done` pulse, and any read data returning after reset SHALL be discarded.

Verification
REQ-028 Bench: vl=4, vs1=1, vs2=2, vd=3, elements A=2.0 and B=3.0 (0x40000000 * 0x40400000), `wr_ready`=1 -> `rd_en` high for 4 consecutive cycles, 4 writes of 0x40C00000 with idx 0..3 on consecutive cycles, `done` pulsed once, then `cmd_ready`=1.
REQ-029 Bench: vl=0 -> no `rd_en`, no `wr_valid`, `done` pulsed on the cycle after accept.
REQ-030 Bench: vl=40 -> exactly 32 reads and 32 writes, idx 0..31.
REQ-031 Bench: vl=8 with `wr_ready` low for 5 cycles mid-stream -> `wr_data`/`wr_idx` held stable while stalled, no more than 2 reads outstanding beyond the result register, all 8 writes delivered in order, none duplicated.
REQ-032 Bench: one element 0x7FC00000 (NaN) * 1.0 -> `nan_seen`=1 after its write, and `nan_seen` clears on the next command accept.
REQ-033 Bench: reset asserted 2 cycles after accepting vl=8 -> the next cycle shows IDLE, `cmd_ready`=1, and no `wr_valid` or `done` afterwards.
